// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides:
// FSM encodings and default framing parameters.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

endpackage

// File: rtl/uart_receiver_if.sv
// CPU-side receive bus: received byte, completion/error pulses and busy flag.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_status;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_status,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_status,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
// All flops reset to the idle-high line level so reset never looks like a start.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic uart_rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic rx_s_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            meta   <= uart_rx;
            rx_s   <= meta;
            rx_s_d <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled: start-bit glitch filter, LSB-first
// shift register, one-cycle data-valid and framing-error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    uart_receiver_if.master   rx
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 fall;
    logic [1:0]           state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    // rx_busy is updated on every state transition so it tracks state != IDLE
    // in the same cycle as the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick         <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx.rx_data   <= '0;
            rx.rx_status <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.rx_busy   <= 1'b0;
        end else begin
            rx.rx_status <= 1'b0;
            rx.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state      <= START;
                        tick       <= '0;
                        rx.rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (tick == TICK_HALF) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            tick    <= '0;
                            bit_idx <= '0;
                        end else begin
                            state      <= IDLE;
                            rx.rx_busy <= 1'b0;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == TICK_LAST) begin
                        tick  <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        // bit_idx holds at its last value instead of wrapping.
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick == TICK_LAST) begin
                        if (rx_s) begin
                            rx.rx_data   <= shreg;
                            rx.rx_status <= 1'b1;
                        end else begin
                            rx.frame_err <= 1'b1;
                        end
                        state      <= IDLE;
                        tick       <= '0;
                        rx.rx_busy <= 1'b0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rx.rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a behavioural line driver produces
// frames, a negedge monitor logs output pulses, and each test compares the log.
module tb_uart_receiver;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic uart_rx = 1'b1;

    uart_receiver_if #(.DATA_BITS(8)) rx_if ();

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .rx      (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int         ev_cyc[$];
    logic [7:0] ev_data[$];
    bit         ev_err[$];
    int         busy_first = -1;
    int         busy_last  = -1;
    int         both_high  = 0;

    always @(negedge clk) begin
        if (rx_if.rx_status || rx_if.frame_err) begin
            ev_cyc.push_back(cyc);
            ev_data.push_back(rx_if.rx_data);
            ev_err.push_back(rx_if.frame_err);
        end
        if (rx_if.rx_status && rx_if.frame_err) both_high++;
        if (rx_if.rx_busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
    end

    task automatic clear_mon();
        ev_cyc.delete();
        ev_data.delete();
        ev_err.delete();
        busy_first = -1;
        busy_last  = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered just after a posedge; the start-bit fall lands on the pin at cycle c0.
    // With jitter, interior bit boundaries move by -1/0/+1 cycles from nominal.
    task automatic drive_frame(input logic [7:0] b, input bit stop_ok, input bit jit,
                               output int c0);
        int j[11];
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        j[0]  = 0;
        j[10] = 0;
        for (int i = 1; i < 10; i++) j[i] = jit ? int'($urandom_range(2)) - 1 : 0;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            idle(16 + j[i+1] - j[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        tests++; if (rx_if.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h want 00", rx_if.rx_data); end
        tests++; if (rx_if.rx_status !== 1'b0) begin fails++; $display("FAIL reset_rx_status got %b want 0", rx_if.rx_status); end
        tests++; if (rx_if.frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", rx_if.frame_err); end
        tests++; if (rx_if.rx_busy !== 1'b0) begin fails++; $display("FAIL reset_rx_busy got %b want 0", rx_if.rx_busy); end
        idle(3);
        reset = 1'b1;
        idle(5);
        clear_mon();
    endtask

    task automatic test_single();
        int c0;
        clear_mon();
        drive_frame(8'hA5, 1'b1, 1'b0, c0);
        idle(5);
        tests++; if (ev_cyc.size() !== 1) begin fails++; $display("FAIL single_count got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() >= 1) begin
            tests++; if (ev_cyc[0] !== c0 + 155) begin fails++; $display("FAIL single_pulse_cycle got %0d want %0d", ev_cyc[0], c0 + 155); end
            tests++; if (ev_data[0] !== 8'hA5) begin fails++; $display("FAIL single_data got %h want a5", ev_data[0]); end
            tests++; if (ev_err[0] !== 1'b0) begin fails++; $display("FAIL single_err got %b want 0", ev_err[0]); end
        end
        tests++; if (busy_first !== c0 + 3) begin fails++; $display("FAIL single_busy_first got %0d want %0d", busy_first, c0 + 3); end
        tests++; if (busy_last !== c0 + 154) begin fails++; $display("FAIL single_busy_last got %0d want %0d", busy_last, c0 + 154); end
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        clear_mon();
        drive_frame(8'h00, 1'b1, 1'b0, c0);
        drive_frame(8'hFF, 1'b1, 1'b0, c1);
        idle(5);
        tests++; if (ev_cyc.size() !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", ev_cyc.size()); end
        if (ev_cyc.size() == 2) begin
            tests++; if (ev_cyc[1] - ev_cyc[0] !== 160) begin fails++; $display("FAIL b2b_spacing got %0d want 160", ev_cyc[1] - ev_cyc[0]); end
            tests++; if (ev_data[0] !== 8'h00 || ev_err[0] !== 1'b0) begin fails++; $display("FAIL b2b_first got %h/%b want 00/0", ev_data[0], ev_err[0]); end
            tests++; if (ev_data[1] !== 8'hFF || ev_err[1] !== 1'b0) begin fails++; $display("FAIL b2b_second got %h/%b want ff/0", ev_data[1], ev_err[1]); end
        end
    endtask

    task automatic test_glitch();
        int c0;
        for (int w = 5; w <= 7; w += 2) begin
            clear_mon();
            c0 = cyc;
            uart_rx = 1'b0;
            idle(w);
            uart_rx = 1'b1;
            idle(30);
            tests++; if (ev_cyc.size() !== 0) begin fails++; $display("FAIL glitch%0d_pulses got %0d want 0", w, ev_cyc.size()); end
            tests++; if (busy_first !== c0 + 3 || busy_last !== c0 + 10) begin
                fails++; $display("FAIL glitch%0d_busy got %0d..%0d want %0d..%0d", w, busy_first, busy_last, c0 + 3, c0 + 10);
            end
            tests++; if (rx_if.rx_data !== 8'hFF) begin fails++; $display("FAIL glitch%0d_data got %h want ff", w, rx_if.rx_data); end
        end
    endtask

    task automatic test_frame_err();
        int c0, c1;
        clear_mon();
        drive_frame(8'h12, 1'b1, 1'b0, c0);
        drive_frame(8'h3C, 1'b0, 1'b0, c1);
        idle(200);
        tests++; if (ev_cyc.size() !== 2) begin fails++; $display("FAIL ferr_count got %0d want 2", ev_cyc.size()); end
        if (ev_cyc.size() == 2) begin
            tests++; if (ev_err[0] !== 1'b0 || ev_data[0] !== 8'h12) begin fails++; $display("FAIL ferr_prior got %h/%b want 12/0", ev_data[0], ev_err[0]); end
            tests++; if (ev_err[1] !== 1'b1) begin fails++; $display("FAIL ferr_flag got %b want 1", ev_err[1]); end
            tests++; if (ev_cyc[1] !== c1 + 155) begin fails++; $display("FAIL ferr_cycle got %0d want %0d", ev_cyc[1], c1 + 155); end
        end
        tests++; if (rx_if.rx_data !== 8'h12) begin fails++; $display("FAIL ferr_data_held got %h want 12", rx_if.rx_data); end
        tests++; if (busy_last !== c1 + 154) begin fails++; $display("FAIL ferr_low_line_busy got %0d want %0d", busy_last, c1 + 154); end
        uart_rx = 1'b1;
        idle(20);
        clear_mon();
        drive_frame(8'h77, 1'b1, 1'b0, c0);
        idle(5);
        tests++; if (ev_cyc.size() !== 1 || rx_if.rx_data !== 8'h77) begin
            fails++; $display("FAIL ferr_recover got %0d pulses data %h want 1 pulse data 77", ev_cyc.size(), rx_if.rx_data);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        logic [9:0] fr;
        clear_mon();
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rx = fr[i];
            idle(16);
        end
        uart_rx = fr[5];
        idle(8);
        reset = 1'b0;
        #1;
        tests++; if (rx_if.rx_data !== 8'h00 || rx_if.rx_busy !== 1'b0 || rx_if.rx_status !== 1'b0 || rx_if.frame_err !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs got data %h busy %b st %b err %b want all 0",
                              rx_if.rx_data, rx_if.rx_busy, rx_if.rx_status, rx_if.frame_err);
        end
        uart_rx = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(200);
        tests++; if (ev_cyc.size() !== 0) begin fails++; $display("FAIL midreset_no_pulse got %0d want 0", ev_cyc.size()); end
        clear_mon();
        drive_frame(8'h5A, 1'b1, 1'b0, c0);
        idle(5);
        tests++; if (ev_cyc.size() !== 1 || rx_if.rx_data !== 8'h5A) begin
            fails++; $display("FAIL midreset_clean got %0d pulses data %h want 1 pulse data 5a", ev_cyc.size(), rx_if.rx_data);
        end
    endtask

    task automatic test_loopback_skew();
        int c0;
        logic [7:0] bytes [3];
        bytes = '{8'h55, 8'h01, 8'h80};
        clear_mon();
        for (int i = 0; i < 3; i++) drive_frame(bytes[i], 1'b1, 1'b1, c0);
        idle(5);
        tests++; if (ev_cyc.size() !== 3) begin fails++; $display("FAIL skew_count got %0d want 3", ev_cyc.size()); end
        for (int i = 0; i < 3 && i < ev_cyc.size(); i++) begin
            tests++; if (ev_data[i] !== bytes[i] || ev_err[i] !== 1'b0) begin
                fails++; $display("FAIL skew_byte%0d got %h/%b want %h/0", i, ev_data[i], ev_err[i], bytes[i]);
            end
        end
    endtask

    task automatic test_random();
        int c0, gap;
        bit ok, prev_bad;
        logic [7:0] b, hold;
        logic [7:0] exp_data[$];
        bit exp_err[$];
        hold = 8'h5A;
        prev_bad = 1'b0;
        clear_mon();
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            ok  = ($urandom_range(3) != 0);
            gap = int'($urandom_range(12));
            if (prev_bad && gap == 0) gap = 1;
            if (gap > 0) begin
                uart_rx = 1'b1;
                idle(gap);
            end
            drive_frame(b, ok, 1'b1, c0);
            exp_err.push_back(!ok);
            exp_data.push_back(ok ? b : hold);
            if (ok) hold = b;
            prev_bad = !ok;
        end
        uart_rx = 1'b1;
        idle(20);
        tests++; if (ev_cyc.size() !== exp_err.size()) begin
            fails++; $display("FAIL rand_count got %0d want %0d", ev_cyc.size(), exp_err.size());
        end
        for (int i = 0; i < exp_err.size() && i < ev_cyc.size(); i++) begin
            tests++; if (ev_err[i] !== exp_err[i] || (!exp_err[i] && ev_data[i] !== exp_data[i])) begin
                fails++; $display("FAIL rand_frame%0d got %h/%b want %h/%b", i, ev_data[i], ev_err[i], exp_data[i], exp_err[i]);
            end
        end
        tests++; if (rx_if.rx_data !== hold) begin fails++; $display("FAIL rand_final_data got %h want %h", rx_if.rx_data, hold); end
    endtask

    task automatic test_exclusive();
        tests++; if (both_high !== 0) begin fails++; $display("FAIL pulse_exclusive got %0d overlaps want 0", both_high); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_loopback_skew();
        test_random();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
